// File: rtl/instr_fetch_unit.sv
// IF stage: PC, word-addressed instruction memory with a load port, and the registered
// opcode/hazardflag pair consumed by the IF/ID register.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH   = 64,
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  localparam int unsigned AW          = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   opcode,
  output logic          hazardflag,
  output logic [31:0]   pc,
  output logic          halted
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_FETCH, S_FLUSH, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc_nxt, opcode_nxt;
  logic          hazardflag_nxt, halted_nxt;
  logic [CW-1:0] flush_cnt, flush_cnt_nxt;

  logic [31:0]   mem [IMEM_DEPTH];
  logic [AW-1:0] ridx;
  logic [31:0]   rword;

  // Upper PC bits are ignored for lookup so the fetch wraps modulo the memory depth.
  assign ridx  = pc[AW+1:2];
  assign rword = mem[ridx];

  // Program load port; not gated by reset so memory can be filled while the core is held.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      opcode     <= 32'h0;
      hazardflag <= 1'b0;
      halted     <= 1'b0;
      flush_cnt  <= CW'(0);
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      opcode     <= opcode_nxt;
      hazardflag <= hazardflag_nxt;
      halted     <= halted_nxt;
      flush_cnt  <= flush_cnt_nxt;
    end
  end

  // Next-state: HALT > branch > stall > FLUSH/FETCH.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    opcode_nxt     = opcode;
    hazardflag_nxt = 1'b0;
    halted_nxt     = halted;
    flush_cnt_nxt  = flush_cnt;

    if (state == S_HALT) begin
      opcode_nxt = 32'h0;
      halted_nxt = 1'b1;
    end else if (branch_taken) begin
      pc_nxt         = branch_target & ~32'h3;
      opcode_nxt     = 32'h0;
      hazardflag_nxt = 1'b1;
      flush_cnt_nxt  = CW'(FLUSH_CYCLES - 1);
      state_nxt      = (FLUSH_CYCLES > 1) ? S_FLUSH : S_FETCH;
    end else if (stall) begin
      hazardflag_nxt = 1'b0;
    end else if (state == S_FLUSH) begin
      hazardflag_nxt = 1'b1;
      opcode_nxt     = 32'h0;
      flush_cnt_nxt  = flush_cnt - CW'(1);
      if (flush_cnt <= CW'(1)) begin
        state_nxt = S_FETCH;
      end
    end else if (rword == HALT_WORD) begin
      opcode_nxt = 32'h0;
      halted_nxt = 1'b1;
      state_nxt  = S_HALT;
    end else begin
      opcode_nxt = rword;
      pc_nxt     = pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with FLUSH_CYCLES=1, one with 3,
// sharing stimulus; each test task checks its own expected values inline.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_we;
  logic [31:0] branch_target, imem_wdata;
  logic [5:0]  imem_waddr;
  logic [31:0] op1, pc1, op3, pc3;
  logic        hf1, h1, hf3, h3;

  logic [31:0] img [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_DEPTH(64), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .opcode(op1), .hazardflag(hf1), .pc(pc1), .halted(h1));

  instr_fetch_unit #(.IMEM_DEPTH(64), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .opcode(op3), .hazardflag(hf3), .pc(pc3), .halted(h3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    imem_waddr = 6'(a);
    imem_wdata = d;
    imem_we    = 1'b1;
    tick();
    imem_we    = 1'b0;
    img[a]     = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_program();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) wr(i, {16'hC0DE, 16'(i)});
    wr(0, 32'hAAAA_0000);
    wr(1, 32'hBBBB_0001);
    wr(2, 32'hCCCC_0002);
    wr(3, 32'hDDDD_0003);
    wr(8, 32'hEEEE_0008);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    if (pc1 !== 32'h0) begin $display("FAIL reset_pc1: got %h want 0", pc1); n_bad++; end n_cmp++;
    if (op1 !== 32'h0) begin $display("FAIL reset_op1: got %h want 0", op1); n_bad++; end n_cmp++;
    if (hf1 !== 1'b0) begin $display("FAIL reset_hf1: got %b want 0", hf1); n_bad++; end n_cmp++;
    if (h1 !== 1'b0) begin $display("FAIL reset_halt1: got %b want 0", h1); n_bad++; end n_cmp++;
    if (pc3 !== 32'h0) begin $display("FAIL reset_pc3: got %h want 0", pc3); n_bad++; end n_cmp++;
    if (hf3 !== 1'b0) begin $display("FAIL reset_hf3: got %b want 0", hf3); n_bad++; end n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (op1 !== img[k]) begin $display("FAIL seq_op[%0d]: got %h want %h", k, op1, img[k]); n_bad++; end n_cmp++;
      if (pc1 !== 32'(4 * (k + 1))) begin $display("FAIL seq_pc[%0d]: got %h want %h", k, pc1, 4 * (k + 1)); n_bad++; end n_cmp++;
      if (hf1 !== 1'b0) begin $display("FAIL seq_hf[%0d]: got %b want 0", k, hf1); n_bad++; end n_cmp++;
      if (op3 !== img[k]) begin $display("FAIL seq_op3[%0d]: got %h want %h", k, op3, img[k]); n_bad++; end n_cmp++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (op1 !== 32'hBBBB_0001) begin $display("FAIL stall_op[%0d]: got %h want bbbb0001", k, op1); n_bad++; end n_cmp++;
      if (pc1 !== 32'h8) begin $display("FAIL stall_pc[%0d]: got %h want 8", k, pc1); n_bad++; end n_cmp++;
    end
    stall = 1'b0;
    tick();
    if (op1 !== 32'hCCCC_0002) begin $display("FAIL stall_resume_op: got %h want cccc0002", op1); n_bad++; end n_cmp++;
    if (pc1 !== 32'hC) begin $display("FAIL stall_resume_pc: got %h want c", pc1); n_bad++; end n_cmp++;
  endtask

  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0021;
    tick();
    branch_taken  = 1'b0;
    if (pc1 !== 32'h20) begin $display("FAIL br_pc: got %h want 20", pc1); n_bad++; end n_cmp++;
    if (op1 !== 32'h0) begin $display("FAIL br_op: got %h want 0", op1); n_bad++; end n_cmp++;
    if (hf1 !== 1'b1) begin $display("FAIL br_hf: got %b want 1", hf1); n_bad++; end n_cmp++;
    tick();
    if (op1 !== 32'hEEEE_0008) begin $display("FAIL br_target_op: got %h want eeee0008", op1); n_bad++; end n_cmp++;
    if (pc1 !== 32'h24) begin $display("FAIL br_target_pc: got %h want 24", pc1); n_bad++; end n_cmp++;
    if (hf1 !== 1'b0) begin $display("FAIL br_hf_drop: got %b want 0", hf1); n_bad++; end n_cmp++;
  endtask

  task automatic test_flush3();
    do_reset();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0020;
    tick();
    branch_taken  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (hf3 !== 1'b1) begin $display("FAIL fl3_hf[%0d]: got %b want 1", k, hf3); n_bad++; end n_cmp++;
      if (op3 !== 32'h0) begin $display("FAIL fl3_op[%0d]: got %h want 0", k, op3); n_bad++; end n_cmp++;
      if (pc3 !== 32'h20) begin $display("FAIL fl3_pc[%0d]: got %h want 20", k, pc3); n_bad++; end n_cmp++;
      tick();
    end
    if (hf3 !== 1'b0) begin $display("FAIL fl3_hf_end: got %b want 0", hf3); n_bad++; end n_cmp++;
    if (op3 !== 32'hEEEE_0008) begin $display("FAIL fl3_target_op: got %h want eeee0008", op3); n_bad++; end n_cmp++;
    if (pc3 !== 32'h24) begin $display("FAIL fl3_target_pc: got %h want 24", pc3); n_bad++; end n_cmp++;
  endtask

  task automatic test_flush_restart();
    do_reset();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0020;
    tick();
    branch_taken  = 1'b0;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0000;
    tick();
    branch_taken  = 1'b0;
    if (pc3 !== 32'h0) begin $display("FAIL rst_br_pc: got %h want 0", pc3); n_bad++; end n_cmp++;
    for (int k = 0; k < 3; k++) begin
      if (hf3 !== 1'b1) begin $display("FAIL rst_br_hf[%0d]: got %b want 1", k, hf3); n_bad++; end n_cmp++;
      tick();
    end
    if (op3 !== img[0]) begin $display("FAIL rst_br_op: got %h want %h", op3, img[0]); n_bad++; end n_cmp++;
    if (pc3 !== 32'h4) begin $display("FAIL rst_br_pc_end: got %h want 4", pc3); n_bad++; end n_cmp++;
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0020;
    tick();
    branch_taken  = 1'b0;
    reset = 1'b1;
    tick();
    if (pc3 !== 32'h0) begin $display("FAIL rif_pc: got %h want 0", pc3); n_bad++; end n_cmp++;
    if (hf3 !== 1'b0) begin $display("FAIL rif_hf: got %b want 0", hf3); n_bad++; end n_cmp++;
    reset = 1'b0;
    tick();
    if (op3 !== img[0]) begin $display("FAIL rif_fetch_op: got %h want %h", op3, img[0]); n_bad++; end n_cmp++;
    if (hf3 !== 1'b0) begin $display("FAIL rif_fetch_hf: got %b want 0", hf3); n_bad++; end n_cmp++;
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_00FC;
    tick();
    branch_taken  = 1'b0;
    tick();
    if (op1 !== img[63]) begin $display("FAIL wrap_last_op: got %h want %h", op1, img[63]); n_bad++; end n_cmp++;
    if (pc1 !== 32'h100) begin $display("FAIL wrap_pc: got %h want 100", pc1); n_bad++; end n_cmp++;
    tick();
    if (op1 !== img[0]) begin $display("FAIL wrap_op: got %h want %h", op1, img[0]); n_bad++; end n_cmp++;
    if (pc1 !== 32'h104) begin $display("FAIL wrap_pc_next: got %h want 104", pc1); n_bad++; end n_cmp++;
  endtask

  task automatic test_halt();
    logic [31:0] saved;
    saved = img[2];
    reset = 1'b1;
    wr(2, 32'hFFFF_FFFF);
    do_reset();
    tick();
    tick();
    tick();
    if (op1 !== 32'h0) begin $display("FAIL halt_op: got %h want 0", op1); n_bad++; end n_cmp++;
    if (h1 !== 1'b1) begin $display("FAIL halt_flag: got %b want 1", h1); n_bad++; end n_cmp++;
    if (pc1 !== 32'h8) begin $display("FAIL halt_pc: got %h want 8", pc1); n_bad++; end n_cmp++;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0040;
    tick();
    branch_taken  = 1'b0;
    tick();
    if (pc1 !== 32'h8) begin $display("FAIL halt_br_pc: got %h want 8", pc1); n_bad++; end n_cmp++;
    if (hf1 !== 1'b0) begin $display("FAIL halt_br_hf: got %b want 0", hf1); n_bad++; end n_cmp++;
    if (h1 !== 1'b1) begin $display("FAIL halt_sticky: got %b want 1", h1); n_bad++; end n_cmp++;
    reset = 1'b1;
    wr(2, saved);
    if (h1 !== 1'b0) begin $display("FAIL halt_reset: got %b want 0", h1); n_bad++; end n_cmp++;
    if (pc1 !== 32'h0) begin $display("FAIL halt_reset_pc: got %h want 0", pc1); n_bad++; end n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_read_before_write();
    logic [31:0] old;
    do_reset();
    reset = 1'b1;
    tick();
    old        = img[0];
    reset      = 1'b0;
    imem_waddr = 6'd0;
    imem_wdata = 32'h5555_AAAA;
    imem_we    = 1'b1;
    tick();
    imem_we    = 1'b0;
    img[0]     = 32'h5555_AAAA;
    if (op1 !== old) begin $display("FAIL rbw_old: got %h want %h", op1, old); n_bad++; end n_cmp++;
    do_reset();
    tick();
    if (op1 !== 32'h5555_AAAA) begin $display("FAIL rbw_new: got %h want 5555aaaa", op1); n_bad++; end n_cmp++;
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_we       = 1'b0;
    imem_waddr    = 6'd0;
    imem_wdata    = 32'h0;
    load_program();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_flush3();
    test_flush_restart();
    test_reset_in_flush();
    test_wrap();
    test_halt();
    test_read_before_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
